// File: rtl/huffman_stream_decoder.sv
// Purpose : table-driven Huffman decoder for a packed MSB-first byte stream;
//           each decoded symbol {run,size} is followed by 'size' raw magnitude bits.
// Latency : one decoded symbol every 2 cycles (size=0) or 3 cycles (size>0) once bits are buffered.
// Backpressure: out_ready=0 holds OUT with stable outputs; in_ready drops when the
//           bit buffer cannot take another byte or the decoder sits in ERROR.
// Ports   : clk/reset (async, active high); tbl_we/tbl_idx/tbl_len/tbl_code/tbl_sym
//           write one code table entry; in_valid/in_data/in_ready byte input;
//           out_valid/out_ready/out_run/out_size/out_mag decoded symbol; err/clr_err
//           sticky decode error and its clear.
module huffman_stream_decoder #(
  parameter int H       = 16,
  parameter int MAX_LEN = 16,
  parameter int BUF_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tbl_we,
  input  logic [$clog2(H)-1:0] tbl_idx,
  input  logic [4:0]           tbl_len,
  input  logic [15:0]          tbl_code,
  input  logic [7:0]           tbl_sym,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_run,
  output logic [3:0]           out_size,
  output logic [14:0]          out_mag,
  output logic                 err,
  input  logic                 clr_err
);

  localparam int CW = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {DECODE, MAG, OUT, ERROR} state_t;

  state_t state, state_nxt;

  logic [4:0]  tlen  [H];
  logic [15:0] tcode [H];
  logic [7:0]  tsym  [H];

  logic [BUF_W-1:0] bufr, buf_sh, buf_nx;
  logic [CW-1:0]    cnt, cnt_sh, cnt_nx;
  logic [4:0]       sh;
  logic [3:0]       run_q, size_q;
  logic [14:0]      mag_q, magv;
  logic             err_q;
  logic [15:0]      top16, mask, cand;
  logic             hit, size_ok, accept;
  logic [4:0]       hit_len;
  logic [7:0]       hit_sym;

  // Code table; a write and a same-cycle match see the old contents because
  // matching reads these registers before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < H; i++) begin
        tlen[i]  <= '0;
        tcode[i] <= '0;
        tsym[i]  <= '0;
      end
    end else if (tbl_we) begin
      tlen[tbl_idx]  <= tbl_len;
      tcode[tbl_idx] <= tbl_code;
      tsym[tbl_idx]  <= tbl_sym;
    end
  end

  assign top16 = bufr[BUF_W-1 -: 16];

  // Scan from the highest index down so the lowest matching index is kept.
  // Entries longer than MAX_LEN never match.
  always_comb begin
    hit     = 1'b0;
    hit_len = '0;
    hit_sym = '0;
    mask    = '0;
    cand    = '0;
    for (int i = H - 1; i >= 0; i--) begin
      mask = ~(16'hFFFF << tlen[i]);
      cand = top16 >> (5'd16 - tlen[i]);
      if (tlen[i] != 5'd0 && tlen[i] <= 5'(MAX_LEN) &&
          CW'(tlen[i]) <= cnt && cand == (tcode[i] & mask)) begin
        hit     = 1'b1;
        hit_len = tlen[i];
        hit_sym = tsym[i];
      end
    end
  end

  assign size_ok = CW'(size_q) <= cnt;
  assign magv    = 15'(top16 >> (5'd16 - {1'b0, size_q}));

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DECODE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      DECODE: begin
        if (hit)                       state_nxt = (hit_sym[3:0] != 4'd0) ? MAG : OUT;
        else if (cnt >= CW'(MAX_LEN))  state_nxt = ERROR;
      end
      MAG:     if (size_ok)   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = DECODE;
      ERROR:   if (clr_err)   state_nxt = DECODE;
      default: state_nxt = DECODE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state == OUT);
    in_ready  = (cnt <= CW'(BUF_W - 8)) && (state != ERROR);
  end

  // Bit buffer: consume first, then append the new byte right after the
  // bits that survive the shift.
  always_comb begin
    sh = '0;
    if (state == DECODE && hit)  sh = hit_len;
    if (state == MAG && size_ok) sh = {1'b0, size_q};
    accept = in_valid && in_ready;
    buf_sh = bufr << sh;
    cnt_sh = cnt - CW'(sh);
    buf_nx = buf_sh;
    cnt_nx = cnt_sh;
    if (accept) begin
      buf_nx = buf_sh | ({in_data, {(BUF_W-8){1'b0}}} >> cnt_sh);
      cnt_nx = cnt_sh + CW'(8);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bufr   <= '0;
      cnt    <= '0;
      run_q  <= '0;
      size_q <= '0;
      mag_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ERROR && clr_err) begin
        bufr  <= '0;
        cnt   <= '0;
        err_q <= 1'b0;
      end else begin
        bufr <= buf_nx;
        cnt  <= cnt_nx;
      end
      if (state == DECODE && !hit && cnt >= CW'(MAX_LEN)) err_q <= 1'b1;
      if (state == DECODE && hit) begin
        run_q  <= hit_sym[7:4];
        size_q <= hit_sym[3:0];
        mag_q  <= '0;
      end
      if (state == MAG && size_ok) mag_q <= magv;
    end
  end

  assign out_run  = run_q;
  assign out_size = size_q;
  assign out_mag  = mag_q;
  assign err      = err_q;

endmodule

// File: tb/tb_huffman_stream_decoder.sv
module tb_huffman_stream_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        tbl_we;
  logic [3:0]  tbl_idx;
  logic [4:0]  tbl_len;
  logic [15:0] tbl_code;
  logic [7:0]  tbl_sym;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_run;
  logic [3:0]  out_size;
  logic [14:0] out_mag;
  logic        err;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  huffman_stream_decoder #(.H(16), .MAX_LEN(16), .BUF_W(32)) dut (
    .clk(clk), .reset(reset),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_len(tbl_len),
    .tbl_code(tbl_code), .tbl_sym(tbl_sym),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_run(out_run), .out_size(out_size), .out_mag(out_mag),
    .err(err), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] idx, input logic [4:0] len,
                      input logic [15:0] code, input logic [7:0] sym);
    tbl_we = 1'b1; tbl_idx = idx; tbl_len = len; tbl_code = code; tbl_sym = sym;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic load_base();
    load(4'd0, 5'd5, 16'h0015, 8'h69);
    load(4'd1, 5'd2, 16'h0003, 8'h01);
    load(4'd2, 5'd9, 16'h0023, 8'h34);
  endtask

  // Offers one byte; returns at the negedge after the accepting edge.
  task automatic send(input string tag, input logic [7:0] b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 40 && !done; k++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_accept"}, {31'b0, done}, 32'd1);
  endtask

  // Waits for out_valid, checks the symbol, then completes the handshake.
  task automatic expect_out(input string tag, input logic [3:0] run,
                            input logic [3:0] size, input logic [14:0] mag);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_valid"}, {31'b0, seen}, 32'd1);
    chk({tag, "_run"},   32'(out_run),  32'(run));
    chk({tag, "_size"},  32'(out_size), 32'(size));
    chk({tag, "_mag"},   32'(out_mag),  32'(mag));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_len = '0; tbl_code = '0; tbl_sym = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_run",       32'(out_run),   32'd0);
    chk("rst_size",      32'(out_size),  32'd0);
    chk("rst_mag",       32'(out_mag),   32'd0);
    chk("rst_cnt",       32'(dut.cnt),   32'd0);

    // Basic stream with output held off for 5 cycles after the first symbol
    load_base();
    send("s1b0", 8'hF5);
    send("s1b1", 8'hFF);
    send("s1b2", 8'h80);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_run",   32'(out_run),   32'd0);
      chk("hold_size",  32'(out_size),  32'd1);
      chk("hold_mag",   32'(out_mag),   32'd1);
      chk("hold_cnt",   32'(dut.cnt),   32'd21);
      @(negedge clk);
    end
    expect_out("s1o0", 4'd0, 4'd1, 15'h001);
    expect_out("s1o1", 4'd6, 4'd9, 15'h1FF);
    repeat (4) @(negedge clk);
    chk("s1_no_third", 32'(out_valid), 32'd0);
    chk("s1_cnt_left", 32'(dut.cnt),   32'd7);

    // size=0 symbol goes DECODE -> OUT with no MAG cycle
    do_reset();
    load_base();
    load(4'd3, 5'd3, 16'h0002, 8'hF0);
    send("s2b0", 8'h40);
    chk("s2_pre_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("s2_direct_out", 32'(out_valid), 32'd1);
    expect_out("s2o0", 4'd15, 4'd0, 15'h000);
    chk("s2_cnt_left", 32'(dut.cnt), 32'd5);

    // Decode error, clr_err ignored outside ERROR, recovery keeps the table
    do_reset();
    load(4'd1, 5'd2, 16'h0003, 8'h01);
    send("s3b0", 8'h00);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("s3_clr_noeffect_cnt", 32'(dut.cnt), 32'd8);
    chk("s3_clr_noeffect_err", 32'(err),     32'd0);
    send("s3b1", 8'h00);
    @(negedge clk);
    chk("s3_err",       32'(err),       32'd1);
    chk("s3_in_ready",  32'(in_ready),  32'd0);
    chk("s3_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("s3_err_sticky", 32'(err), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("s3_clr_err",      32'(err),      32'd0);
    chk("s3_clr_cnt",      32'(dut.cnt),  32'd0);
    chk("s3_clr_in_ready", 32'(in_ready), 32'd1);
    send("s3b2", 8'hC0);
    expect_out("s3o0", 4'd0, 4'd1, 15'h000);

    // Reset while in MAG, then replay the stream after reloading the table
    do_reset();
    load_base();
    send("s4b0", 8'hF5);
    send("s4b1", 8'hFF);
    chk("s4_in_mag", 32'(dut.state), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("s4_rst_valid", 32'(out_valid), 32'd0);
    chk("s4_rst_err",   32'(err),       32'd0);
    chk("s4_rst_cnt",   32'(dut.cnt),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("s4_in_ready", 32'(in_ready), 32'd1);
    load_base();
    send("s4r0", 8'hF5);
    send("s4r1", 8'hFF);
    send("s4r2", 8'h80);
    expect_out("s4o0", 4'd0, 4'd1, 15'h001);
    expect_out("s4o1", 4'd6, 4'd9, 15'h1FF);
    repeat (4) @(negedge clk);
    chk("s4_cnt_left", 32'(dut.cnt), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
